// File: rtl/alu_adder.sv
// alu_adder: registered two-operand adder with carry, overflow, zero and negative flags.
// The sum is built from 4-bit carry-lookahead groups. Carries ripple between groups,
// so the slowest path is one lookahead term per group plus the final XOR.
module alu_adder #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  input  logic             clk,
  input  logic             rst,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  // WIDTH must be a multiple of 4 and at least 4. The group count below truncates otherwise.
  localparam int GROUPS = WIDTH / 4;

  // Per-bit propagate and generate terms.
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;

  // carry_vec[i] is the carry into bit i. carry_vec[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry_vec;

  // Carry out of each 4-bit group. group_carry[0] is the constant carry-in.
  logic [GROUPS:0]  group_carry;

  // Combinational next-state values for the output register set.
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;
  logic             zero_next;
  logic             neg_next;

  // Output register set. This is the only state in the block.
  logic [WIDTH-1:0] r1_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             neg_reg;

  // Propagate and generate for every bit, one 4-bit group per generate iteration.
  generate
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_pg
      assign p[4*gi +: 4] = r2[4*gi +: 4] ^ r3[4*gi +: 4];
      assign g[4*gi +: 4] = r2[4*gi +: 4] & r3[4*gi +: 4];
    end
  endgenerate

  // Lookahead carries inside each group. The group carry-out ripples into the next group.
  // This is written as one sequential loop so the ripple chain has no feedback
  // through a shared vector.
  always_comb begin
    logic       cin;
    logic [3:0] gp;
    logic [3:0] gg;
    carry_vec   = '0;
    group_carry = '0;
    cin         = 1'b0;
    gp          = '0;
    gg          = '0;
    for (int k = 0; k < GROUPS; k++) begin
      gp = p[4*k +: 4];
      gg = g[4*k +: 4];
      group_carry[k]     = cin;
      carry_vec[4*k]     = cin;
      // c1
      carry_vec[4*k + 1] = gg[0]
                         | (gp[0] & cin);
      // c2
      carry_vec[4*k + 2] = gg[1]
                         | (gp[1] & gg[0])
                         | (gp[1] & gp[0] & cin);
      // c3
      carry_vec[4*k + 3] = gg[2]
                         | (gp[2] & gg[1])
                         | (gp[2] & gp[1] & gg[0])
                         | (gp[2] & gp[1] & gp[0] & cin);
      // c4 is the group carry-out.
      cin                = gg[3]
                         | (gp[3] & gg[2])
                         | (gp[3] & gp[2] & gg[1])
                         | (gp[3] & gp[2] & gp[1] & gg[0])
                         | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
      group_carry[k + 1] = cin;
    end
    carry_vec[WIDTH] = cin;
  end

  // Sum and flags computed from the lookahead carries, ahead of the register.
  always_comb begin
    sum_next  = p ^ carry_vec[WIDTH-1:0];
    cout_next = carry_vec[WIDTH];
    // Signed overflow: the carry into the MSB differs from the carry out of the MSB.
    ovf_next  = carry_vec[WIDTH] ^ carry_vec[WIDTH-1];
    zero_next = ~|sum_next;
    neg_next  = sum_next[WIDTH-1];
  end

  // Register the sum and flags on every edge. Reset wins and loads a consistent zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_reg   <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b1;
      neg_reg  <= 1'b0;
    end else begin
      r1_reg   <= sum_next;
      cout_reg <= cout_next;
      ovf_reg  <= ovf_next;
      zero_reg <= zero_next;
      neg_reg  <= neg_next;
    end
  end

  assign r1   = r1_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;
  assign neg  = neg_reg;

  // The per-group carry vector is kept for debug visibility. This sink keeps lint quiet.
  logic unused_group_carry;
  assign unused_group_carry = ^group_carry;

endmodule

// File: tb/tb_alu_adder.sv
// tb_alu_adder: table-driven directed vectors, hand sequences for reset behaviour,
// and randomised back-to-back sums checked against an arithmetic reference model.
module tb_alu_adder;

  logic [31:0] r1;
  logic [31:0] r2;
  logic [31:0] r3;
  logic        clk;
  logic        rst;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int total;
  int bad;

  alu_adder #(.WIDTH(32)) dut (
    .r1  (r1),
    .r2  (r2),
    .r3  (r3),
    .clk (clk),
    .rst (rst),
    .cout(cout),
    .ovf (ovf),
    .zero(zero),
    .neg (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r1;
    logic        exp_cout;
    logic        exp_ovf;
    logic        exp_zero;
    logic        exp_neg;
  } vec_t;

  vec_t vecs[8];

  // Apply operands and reset on the falling edge, then step just past the next rising edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic rst_v);
    @(negedge clk);
    r2  = a;
    r3  = b;
    rst = rst_v;
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs as one transaction and print one line for it.
  task automatic check(input string name, input logic [31:0] e_r1, input logic e_c,
                       input logic e_o, input logic e_z, input logic e_n);
    logic [35:0] act;
    logic [35:0] exp;
    act = {r1, cout, ovf, zero, neg};
    exp = {e_r1, e_c, e_o, e_z, e_n};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got r1=%h c=%b o=%b z=%b n=%b, want r1=%h c=%b o=%b z=%b n=%b",
               name, r1, cout, ovf, zero, neg, e_r1, e_c, e_o, e_z, e_n);
    end else begin
      $display("ok   %s: r1=%h c=%b o=%b z=%b n=%b", name, r1, cout, ovf, zero, neg);
    end
  endtask

  // Reference model: a 33-bit arithmetic sum, with flags derived from the sign rules.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic        o;
    wide = {1'b0, a} + {1'b0, b};
    o    = (a[31] == b[31]) && (wide[31] != a[31]);
    return {wide[31:0], wide[32], o, (wide[31:0] == 32'd0), wide[31]};
  endfunction

  initial begin
    logic [35:0] exp_q[$];
    logic [35:0] e;
    logic [31:0] a;
    logic [31:0] b;

    total = 0;
    bad   = 0;
    r2    = 32'h1234_5678;
    r3    = 32'h9abc_def0;
    rst   = 1'b1;

    vecs[0] = '{"1+1",        32'd1,         32'd1,         32'd2,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"2+1",        32'd2,         32'd1,         32'd3,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"4+2",        32'd4,         32'd2,         32'd6,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"8+1",        32'd8,         32'd1,         32'd9,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"wrap",       32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{"neg_ovf",    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{"group_chain",32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held for two cycles with arbitrary operands.
    apply(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    check("reset_1", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("reset_2", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].a, vecs[i].b, 1'b0);
      check(vecs[i].name, vecs[i].exp_r1, vecs[i].exp_cout, vecs[i].exp_ovf,
            vecs[i].exp_zero, vecs[i].exp_neg);
    end

    // Mid-stream reset discards 7+7. Releasing reset then loads 7+7 on the next edge.
    apply(32'd5, 32'd5, 1'b0);
    check("stream_5p5", 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(32'd7, 32'd7, 1'b1);
    check("midstream_rst", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(32'd7, 32'd7, 1'b0);
    check("post_rst_7p7", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised back-to-back sums, with new operands every cycle and one-cycle latency.
    // Operand classes are mixed so that sign and carry corners show up often.
    for (int i = 0; i < 1200; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'h7FFF_FFFF - $urandom_range(0, 3); b = $urandom_range(0, 7); end
        2: begin a = $urandom | 32'h8000_0000; b = $urandom | 32'h8000_0000; end
        default: begin a = $urandom; b = (~a) + $urandom_range(0, 2); end
      endcase
      exp_q.push_back(model(a, b));
      apply(a, b, 1'b0);
      e = exp_q.pop_front();
      check($sformatf("rand_%0d", i), e[35:4], e[3], e[2], e[1], e[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_adder.md
# alu_adder

Registered two-operand integer adder for the ALU datapath. Adds operands `r2` and `r3` and drives the sum on `r1` one clock after the operands are sampled. Also registers carry-out, signed-overflow, zero and negative status flags for the ALU flag logic. The RTL module name is `alu_adder`.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width in bits. Must be a multiple of 4 and at least 4.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `r1`: output, WIDTH bits. Registered sum `r2 + r3`.
- `r2`: input, WIDTH bits. Operand A.
- `r3`: input, WIDTH bits. Operand B.
- `cout`: output, 1 bit. Registered unsigned carry out of bit WIDTH-1.
- `ovf`: output, 1 bit. Registered two's-complement signed overflow.
- `zero`: output, 1 bit. Registered; 1 when the registered `r1` equals 0.
- `neg`: output, 1 bit. Registered; equals `r1[WIDTH-1]`.

Positional port order in the module header is fixed: `r1, r2, r3, clk, rst, cout, ovf, zero, neg`. Existing instantiations of the form `(r1, r2, r3)` therefore keep binding correctly.

## Operation

- Sum datapath:
  - Operands are split into WIDTH/4 groups of 4 bits.
  - Each group is a carry-lookahead block computing propagate `p = a^b`, generate `g = a&b` and the group carries c1..c4 from lookahead equations.
  - Group carries ripple from group to group.
  - Carry-in to group 0 is constant 0.
- Unsigned wrap-around: the sum is `(r2 + r3) mod 2^WIDTH`. `cout` is the discarded bit WIDTH.
- Signed overflow: `ovf = carry into MSB XOR carry out of MSB`. Equivalently, the operands have the same sign and the result sign differs.
- `zero` and `neg` are computed from the combinational sum and registered alongside it, so they are always consistent with the current `r1`.
- Inputs are never latched separately. The only state is the output register set: `r1, cout, ovf, zero, neg`.
- X or Z on an input propagates to the outputs; no sanitising is done.

## Timing

- Latency is one cycle: operands present before rising edge N appear on `r1` and the flags after edge N.
- Throughput is one addition per cycle. There is no handshake and no enable; the outputs reload on every non-reset edge.
- Reset:
  - When `rst`=1 at a rising edge: `r1`=0, `cout`=0, `ovf`=0, `neg`=0, `zero`=1. The flags stay consistent with `r1`=0.
  - Reset takes priority over loading.
  - If reset is asserted mid-stream, that cycle's operands are discarded.
  - The first post-reset edge with `rst`=0 loads the current operands normally.
- Before the first clock edge the outputs are undefined. The bench must apply reset or tolerate X until the first edge.
- The combinational path from `r2`/`r3` to the output register must close timing at the ALU clock. The group-lookahead structure is mandatory; a single behavioural `+` is not accepted.

## Test plan

- Reset: hold `rst`=1 for 2 cycles with arbitrary operands -> `r1`=0, `cout`=0, `ovf`=0, `neg`=0, `zero`=1.
- Basic sums, with operands changed every 10 time units and sampled one edge later:
  - 1+1 -> 2
  - 2+1 -> 3
  - 4+2 -> 6
  - 8+1 -> 9
  - All of these with every flag 0.
- Unsigned wrap: 0xFFFFFFFF + 0x00000001 -> `r1`=0, `cout`=1, `zero`=1, `ovf`=0, `neg`=0.
- Signed overflow:
  - 0x7FFFFFFF + 1 -> 0x80000000, `ovf`=1, `neg`=1, `cout`=0.
  - 0x80000000 + 0x80000000 -> 0, `ovf`=1, `cout`=1, `zero`=1.
- Group carry chain: 0x0000FFFF + 0x00000001 -> 0x00010000, with the carry crossing four 4-bit groups, all flags 0.
- Mid-stream reset: stream 5+5 then 7+7, asserting `rst` on the edge that would load 7+7 -> outputs return to reset values. Releasing `rst` with 7+7 still applied -> 14 after the next edge.
- Randomised back-to-back pairs (at least 1000) compared against a golden `(a+b) mod 2^32` model with one-cycle delay.
